// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the HI/LO multiply/divide sequencer.
//   - op encodings issued by decode (MD_MULT/MD_MULTU/MD_DIV/MD_DIVU)
//   - sequencer state enum
//   - operand width XLEN and iteration count ITERS
//   - hilo_we bit positions (HILO_WE_HI / HILO_WE_LO)
//   - small helpers for op classification and two's-complement negation
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int DW    = 2 * XLEN;
    localparam int ITERS = XLEN;

    localparam int HILO_WE_HI = 1;
    localparam int HILO_WE_LO = 0;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    function automatic logic is_div_op(input logic [1:0] op);
        return op[1];
    endfunction

    // MULT and DIV are the signed flavours (op[0] clear).
    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v);
        return ~v + XLEN'(1);
    endfunction

    function automatic logic [DW-1:0] neg_dw(input logic [DW-1:0] v);
        return ~v + DW'(1);
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// hilo_muldiv_ctrl_if: decode/execute <-> mul/div sequencer bundle.
//   master (decode side): start_valid, op, src_a, src_b, flush
//   slave  (sequencer)  : busy, done, hilo_we, hi_wdata, lo_wdata
interface hilo_muldiv_ctrl_if;
    import muldiv_pkg::*;

    logic            start_valid;
    logic [1:0]      op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [1:0]      hilo_we;
    logic [XLEN-1:0] hi_wdata;
    logic [XLEN-1:0] lo_wdata;

    modport master (
        output start_valid, op, src_a, src_b, flush,
        input  busy, done, hilo_we, hi_wdata, lo_wdata
    );

    modport slave (
        input  start_valid, op, src_a, src_b, flush,
        output busy, done, hilo_we, hi_wdata, lo_wdata
    );

endinterface

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: shared shift/add datapath for unsigned magnitudes.
//   clk, resetn  : clock, async active-low reset
//   load         : hi <- 0, lo <- load_lo_i, operand register <- load_m_i
//   step         : perform one iteration
//   is_div       : 1 = restoring divide step, 0 = shift-add multiply step
//   load_m_i     : multiplicand (mul) or divisor (div) magnitude
//   load_lo_i    : multiplier (mul) or dividend (div) magnitude
//   hi, lo       : result of the current step (value the registers take on step)
// Multiply: {hi,lo} ends as the 64-bit product after XLEN steps.
// Divide  : hi ends as remainder, lo as quotient after XLEN steps.
module muldiv_iter_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            load,
    input  logic            step,
    input  logic            is_div,
    input  logic [XLEN-1:0] load_m_i,
    input  logic [XLEN-1:0] load_lo_i,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    logic [XLEN-1:0] m_q;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN:0]   opnd;
    logic [XLEN:0]   addend;
    logic [XLEN:0]   sum;
    logic            cout;

    // One (XLEN+1)-bit adder serves both ops; subtract is add of the inverted
    // divisor with carry-in, so carry-out set means the trial did not borrow.
    always_comb begin
        if (is_div) begin
            opnd   = {hi_q, lo_q[XLEN-1]};
            addend = ~{1'b0, m_q};
        end else begin
            opnd   = {1'b0, hi_q};
            addend = lo_q[0] ? {1'b0, m_q} : '0;
        end
        {cout, sum} = {1'b0, opnd} + {1'b0, addend} + {{(XLEN+1){1'b0}}, is_div};

        if (is_div) begin
            // A kept (non-borrowing) remainder is always below the divisor,
            // so dropping the top bit of opnd/sum is lossless.
            hi_d = cout ? sum[XLEN-1:0] : opnd[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], cout};
        end else begin
            hi_d = sum[XLEN:1];
            lo_d = {sum[0], lo_q[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_q  <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else if (load) begin
            m_q  <= load_m_i;
            hi_q <= '0;
            lo_q <= load_lo_i;
        end else if (step) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi = hi_d;
    assign lo = lo_d;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the
// HI/LO write port.
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   md     : slave side of hilo_muldiv_ctrl_if (start/op/operands/flush in,
//            busy/done/hilo_we/hi_wdata/lo_wdata out)
// Build option HILO_FAST_MUL_EN: multiplies finish through a single-cycle
// multiplier (DONE the cycle after accept); division stays iterative.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start_valid; operands latched on accept
// ST_MUL  | shift-add multiply, one bit per cycle, ITERS cycles
// ST_DIV  | restoring divide, one quotient bit per cycle, ITERS cycles
// ST_DONE | one-cycle HI/LO write (masked by flush)
module hilo_muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    hilo_muldiv_ctrl_if.slave md
);

    localparam logic [5:0] CNT_LAST = 6'(ITERS - 1);

    md_state_e       state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic            rem_neg_q, rem_neg_d;
    logic            busy_q;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;

    logic            accept;
    logic            core_step;
    logic            sign_a, sign_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN-1:0] ld_m, ld_lo;
    logic [XLEN-1:0] core_hi, core_lo;
    logic            wr_en;
    logic [1:0]      we;

    assign accept = (state_q == ST_IDLE) && md.start_valid && !md.flush;

    // Negating 0x80000000 yields 0x80000000, which read as unsigned is the
    // correct magnitude 2^31; the core works on unsigned magnitudes only.
    assign sign_a = is_signed_op(md.op) & md.src_a[XLEN-1];
    assign sign_b = is_signed_op(md.op) & md.src_b[XLEN-1];
    assign mag_a  = sign_a ? neg_w(md.src_a) : md.src_a;
    assign mag_b  = sign_b ? neg_w(md.src_b) : md.src_b;

    assign ld_m  = is_div_op(md.op) ? mag_b : mag_a;
    assign ld_lo = is_div_op(md.op) ? mag_a : mag_b;

`ifdef HILO_FAST_MUL_EN
    logic [DW-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif

    muldiv_iter_core #(.XLEN(XLEN)) u_core (
        .clk       (clk),
        .resetn    (resetn),
        .load      (accept),
        .step      (core_step),
        .is_div    (is_div_op(op_q)),
        .load_m_i  (ld_m),
        .load_lo_i (ld_lo),
        .hi        (core_hi),
        .lo        (core_lo)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        core_step = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d      = md.op;
                    cnt_d     = '0;
                    neg_d     = sign_a ^ sign_b;
                    rem_neg_d = sign_a;
                    if (is_div_op(md.op)) begin
                        if (md.src_b == '0) begin
                            hi_d    = md.src_a;
                            lo_d    = '1;
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_DIV;
                        end
                    end else begin
`ifdef HILO_FAST_MUL_EN
                        {hi_d, lo_d} = (sign_a ^ sign_b) ? neg_dw(fast_prod) : fast_prod;
                        state_d      = ST_DONE;
`else
                        state_d = ST_MUL;
`endif
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                core_step = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // Core outputs already carry the final step's result.
                    state_d = ST_DONE;
                    if (state_q == ST_MUL) begin
                        {hi_d, lo_d} = neg_q ? neg_dw({core_hi, core_lo}) : {core_hi, core_lo};
                    end else begin
                        hi_d = rem_neg_q ? neg_w(core_hi) : core_hi;
                        lo_d = neg_q ? neg_w(core_lo) : core_lo;
                    end
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // An aborted op must leave the result registers untouched.
        if (md.flush) begin
            state_d = ST_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            busy_q    <= (state_d != ST_IDLE);
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign wr_en = (state_q == ST_DONE) && !md.flush;

    always_comb begin
        we             = '0;
        we[HILO_WE_HI] = wr_en;
        we[HILO_WE_LO] = wr_en;
    end

    assign md.busy     = busy_q;
    assign md.done     = wr_en;
    assign md.hilo_we  = we;
    assign md.hi_wdata = hi_q;
    assign md.lo_wdata = lo_q;

endmodule

// File: doc/hilo_muldiv_ctrl.md
# hilo_muldiv_ctrl

Multi-cycle multiply/divide sequencer that owns the HI/LO write port. It sits beside the execute stage. It accepts MULT/MULTU/DIV/DIVU operands issued from decode, iterates a shared shift/add datapath, and holds `busy` so decode stalls any further HI/LO access until the result is written. An exception flush from the CP0 path aborts an in-flight operation without touching HI/LO.

## Interface
- `XLEN`, 32, operand width; `ITERS` derives from it (`ITERS = XLEN`).
- `clk` in 1: rising-edge clock.
- `resetn` in 1: asynchronous, active-low reset.
- `start_valid` in 1: decode issues a mul/div this cycle.
- `op` in 2: 2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU.
- `src_a` in XLEN: rs operand (multiplicand / dividend).
- `src_b` in XLEN: rt operand (multiplier / divisor).
- `flush` in 1: CP0 exception/eret flush; kills the in-flight op.
- `busy` out 1: operation in flight. Decode stalls mul/div/mfhi/mflo/mthi/mtlo while high.
- `done` out 1: one-cycle pulse when the result is written.
- `hilo_we` out 2: [1] HI write, [0] LO write; same encoding as decode's `hilo_we`.
- `hi_wdata` out XLEN: HI result (remainder or product high).
- `lo_wdata` out XLEN: LO result (quotient or product low).

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - `start_valid & ~flush` latches `op`, `src_a` and `src_b`, and clears the counter.
  - MULT/MULTU go to MUL. DIV/DIVU go to DIV.
  - DIV/DIVU with `src_b == 0` goes straight to DONE.
- Signed ops:
  - Absolute values of both operands are taken at accept, and the sign flags are latched.
  - The most-negative input (0x80000000) is handled as unsigned magnitude 2^31 in a 33-bit path.
- MUL: radix-2 shift-add over a 64-bit accumulator, one bit per cycle, `ITERS` cycles. In the final cycle the product is negated if signed and the sign flags differ.
- DIV: restoring division. Each cycle does a 33-bit trial subtract of the divisor from {remainder, next dividend bit}, for `ITERS` cycles. Sign fixups:
  - Quotient is negated if signed and the signs differ.
  - Remainder takes the dividend's sign.
- Divide by zero: LO = 0xFFFFFFFF and HI = `src_a` unmodified, for both signed and unsigned.
- The counter is 6 bits and saturates at `ITERS-1`. Leaving MUL/DIV goes to DONE.
- DONE:
  - `hilo_we = 2'b11` and `done = 1` for exactly one cycle.
  - `hi_wdata`/`lo_wdata` hold the final result; outputs are registered.
  - Next state is IDLE.
- `start_valid` is ignored while not IDLE. Decode never asserts it then; the bench checks this.
- `flush`:
  - In any state, `flush` forces IDLE next cycle.
  - `flush` combinationally masks `hilo_we` and `done` to 0 in the same cycle, including in DONE.
  - `flush` together with `start_valid` in IDLE does not accept the op.
- Reset values: state IDLE, `busy` 0, `done` 0, `hilo_we` 2'b00, `hi_wdata`/`lo_wdata` 0, counter 0.

## Timing
- Accept at cycle N. Then `busy` = 1 from N+1 until DONE is exited, and `busy` = (state != IDLE), registered.
- Iterative mul/div:
  - Iterations run in cycles N+1..N+32.
  - DONE occurs at N+33 (`done`, `hilo_we`).
  - IDLE at N+34; a new start is accepted at N+34.
- Divide by zero: DONE at N+1, IDLE at N+2.
- Flush at cycle F: state IDLE at F+1, `busy` 0 at F+1, a new start is accepted at F+1.
- Asynchronous reset mid-operation forces all outputs to their reset values immediately. No HI/LO write occurs.

## Configuration
- `HILO_FAST_MUL_EN`:
  - Defined: MULT/MULTU skip MUL. The 64-bit product is computed with a single-cycle multiplier from the latched operands, and DONE occurs at N+1.
  - Undefined: 32-cycle iterative multiply as above.
- Division is always iterative.

## Structure
- Shared package `muldiv_pkg`: `op` encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU), state enum, `ITERS`, and the `hilo_we` bit positions (HILO_WE_HI = 1, HILO_WE_LO = 0).
- Sub-module `muldiv_iter_core` contains:
  - 64-bit shift register.
  - 33-bit adder/subtractor.
  - Step control inputs (`load`, `step`, `is_div`) and `hi`/`lo` result outputs.
- `hilo_muldiv_ctrl` holds the FSM, counter, sign handling, flush masking and output registers.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, accept at N → `done`/`hilo_we`=2'b11 at N+33, HI=0xFFFFFFFE, LO=0x00000001; `busy` high N+1..N+33.
- MULT 0xFFFFFFFD (−3) × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. With `HILO_FAST_MUL_EN`: same result, `done` at N+1.
- DIV 0xFFFFFFF9 (−7) ÷ 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 0x80000000 ÷ 3 → LO=0x2AAAAAAA, HI=0x00000002.
- DIVU 7 ÷ 0 → `done` at N+1, LO=0xFFFFFFFF, HI=0x00000007; `busy` 0 at N+2.
- DIV started at N, `flush` at N+10 → `hilo_we` never asserted, `busy` 0 at N+11. MULTU 2×3 accepted at N+11 → LO=6 at N+44. `flush` during DONE → `hilo_we` = 0.
- `resetn` low at N+5 mid-MUL → `busy`/`done`/`hilo_we`/data all 0 immediately. After release, a fresh op completes normally.
